serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 97 +++++++++
 tb/tb_serial_add_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and defaults.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that can hold values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: computes A+B+Cin LSB first, one bit per clock, through
// one full adder. The result is published on Sum/Cout when the last bit is
// done, and these hold their values until the next completed addition.
module serial_add_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .A   (a_reg[0]),
    .B   (b_reg[0]),
    .Cin (carry_reg),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  // Control FSM and datapath: load operands on accepted start, shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            res_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: a running addition cannot be disturbed.
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_cout;
          res_reg   <= {fa_sum, res_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_CNT) begin
            // The final sum bit is still on the adder output, so merge it in directly.
            Sum       <= {fa_sum, res_reg[WIDTH-1:1]};
            Cout      <= fa_cout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one start pulse (optionally held) and record the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
    A     = a;
    B     = b;
    Cin   = c;
    start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    $display("issue A=%02h B=%02h Cin=%0d", a, b, c);
    step();
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done, checking busy and output stability, then score the result.
  task automatic await_result(input string tag, input int cyc0);
    int cyc;
    logic [W:0] e;
    cyc = cyc0;
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    while (done !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold"}, 32'({Cout, Sum}), 32'(last_res));
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(W + 1));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk({tag, "_result"}, 32'({Cout, Sum}), 32'(e));
    $display("result %s Sum=%02h Cout=%0d latency=%0d", tag, Sum, Cout, cyc);
    last_res = e;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;
    last_res = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'({Cout, Sum}), 32'd0);

    // start coinciding with reset must be ignored
    start = 1'b1;
    A = 8'h11;
    B = 8'h22;
    step();
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_start_busy", 32'(busy), 32'd0);
    $display("start during reset ignored, busy=%0d", busy);

    // basic addition
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    await_result("add_0f_01", 1);
    step();
    chk("pulse_end", 32'(done), 32'd0);

    // wrap-around and full-carry cases
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    await_result("wrap_ff_01", 1);
    step();
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    await_result("max_ff_ff_1", 1);
    step();

    // start during RUN is ignored
    issue(8'h3C, 8'h0A, 1'b0, 1'b0);
    step();
    step();
    A = 8'hFF;
    B = 8'hFF;
    Cin = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    await_result("midrun_ignore", 4);
    step();
    chk("midrun_no_second", 32'(busy), 32'd0);

    // reset in the middle of a run aborts it
    issue(8'h55, 8'h11, 1'b1, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    last_res = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out", 32'({Cout, Sum}), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    $display("abort complete Sum=%02h Cout=%0d", Sum, Cout);
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    await_result("after_abort", 1);
    step();

    // start held high: back-to-back results every W+1 cycles
    exp_q.push_back({1'b0, 8'h12} + {1'b0, 8'h34});
    exp_q.push_back({1'b0, 8'hAA} + {1'b0, 8'h55});
    A = 8'h12;
    B = 8'h34;
    Cin = 1'b0;
    start = 1'b1;
    step();
    A = 8'hAA;
    B = 8'h55;
    await_result("held_first", 1);
    step();
    await_result("held_second", 1);
    start = 1'b0;
    step();
    chk("held_idle", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
